// File: rtl/mult_acc_if.sv
// Handshake bundle between the upstream multiplier, mult_acc and the
// downstream consumer. The master side drives products and accepts results;
// the slave side is the accumulator itself.
interface mult_acc_if;
  logic        prod_valid;
  logic [15:0] prod;
  logic        prod_ready;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] acc_out;
  logic        ovf;

  modport master (
    output prod_valid, prod, out_ready,
    input  prod_ready, out_valid, acc_out, ovf
  );

  modport slave (
    input  prod_valid, prod, out_ready,
    output prod_ready, out_valid, acc_out, ovf
  );
endinterface

// File: rtl/mult_acc.sv
// mult_acc: sums N_SAMPLES unsigned 16-bit products into a 20-bit result and
// presents it on a valid/ready output. Overflow past 20 bits sets a sticky ovf.
// Optional build macro MULT_ACC_SAT_EN: clamp the sum at 0xFFFFF instead of
// wrapping modulo 2^20.
module mult_acc #(
  parameter int unsigned N_SAMPLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  mult_acc_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_e;

  localparam logic [7:0] N_LAST = 8'(N_SAMPLES);

  state_e      state_q, state_d;
  logic        alive_q;
  logic [19:0] acc_q, acc_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        ovf_q, ovf_d;

  logic        prod_ready_s;
  logic        out_valid_s;
  logic        beat_in;
  logic        xfer;
  logic        last_beat;
  logic [7:0]  cnt_inc;
  logic [20:0] sum;

  assign beat_in   = bus.prod_valid && prod_ready_s;
  assign xfer      = out_valid_s && bus.out_ready;
  assign cnt_inc   = cnt_q + 8'd1;
  assign last_beat = (cnt_inc == N_LAST);
  assign sum       = {1'b0, acc_q} + {5'b0, bus.prod};

  // State register; alive_q keeps prod_ready low until the first edge out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q <= IDLE;
      alive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      alive_q <= 1'b1;
    end
  end

  // Next-state logic: clr overrides everything, including a HOLD transfer.
  always_comb begin
    // NOTE: default assignment first so no path through the block leaves
    // state_d unassigned, which would otherwise infer a latch.
    state_d = state_q;
    if (clr) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, ACC: if (beat_in) state_d = last_beat ? HOLD : ACC;
        HOLD:      if (xfer)    state_d = IDLE;
        default:   state_d = IDLE;
      endcase
    end
  end

  // Output logic: handshake flags come from registered state only.
  always_comb begin
    prod_ready_s = alive_q && (state_q != HOLD);
    out_valid_s  = (state_q == HOLD);
  end

  // Accumulator next-value: clear on clr or transfer, load in IDLE, add in ACC.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr || xfer) begin
      acc_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (beat_in) begin
      cnt_d = cnt_inc;
      if (state_q == IDLE) begin
        acc_d = {4'b0, bus.prod};
        ovf_d = 1'b0;
      end else if (sum[20]) begin
        ovf_d = 1'b1;
`ifdef MULT_ACC_SAT_EN
        acc_d = 20'hFFFFF;
`else
        acc_d = sum[19:0];
`endif
      end else begin
        acc_d = sum[19:0];
      end
    end
  end

  // Accumulator registers; reset discards any partial or held result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.prod_ready = prod_ready_s;
  assign bus.out_valid  = out_valid_s;
  assign bus.acc_out    = acc_q;
  assign bus.ovf        = ovf_q;

endmodule
